// File: rtl/dcnn_pkg.sv
// Shared constants and the row receiver state encoding.
// Imported by every row_receiver file and by the bench.
package dcnn_pkg;

    localparam int ROW_PIXELS = 28;
    localparam int PIXEL_W    = 16;
    localparam int ROW_W      = ROW_PIXELS * PIXEL_W;
    localparam int IDX_W      = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_SPLIT = 3'd1,
        ST_GET_DATA  = 3'd2,
        ST_CHECK     = 3'd3,
        ST_HOLD      = 3'd4
    } rx_state_t;

endpackage

// File: rtl/row_receiver_if.sv
// Sender/consumer bundle for row_receiver.
// Transfer on in_valid & in_ready; row taken on row_valid & row_ready.
interface row_receiver_if;
    import dcnn_pkg::*;

    logic               in_valid;
    logic [PIXEL_W-1:0] in_data;
    logic               in_ready;
    logic               split_ack;
    logic [ROW_W-1:0]   row_out;
    logic [15:0]        row_len;
    logic               row_valid;
    logic               row_ready;
    logic               err;
    logic               busy;
    rx_state_t          dbg_state;

    modport slave (
        input  in_valid, in_data, row_ready,
        output in_ready, split_ack, row_out, row_len, row_valid, err, busy, dbg_state
    );

    modport master (
        output in_valid, in_data, row_ready,
        input  in_ready, split_ack, row_out, row_len, row_valid, err, busy, dbg_state
    );

endinterface

// File: rtl/rx_row_buffer.sv
// 448-bit row register with synchronous clear and indexed 16-bit pixel write.
// Clear wins over a write in the same cycle.
module rx_row_buffer
    import dcnn_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_idx,
    input  logic [PIXEL_W-1:0] i_wr_data,
    output logic [ROW_W-1:0]   o_row
);

    logic [ROW_W-1:0] r_row;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_row <= '0;
        end else if (i_wr_en) begin
            r_row[PIXEL_W*i_wr_idx +: PIXEL_W] <= i_wr_data;
        end
    end

    assign o_row = r_row;

endmodule

// File: rtl/row_receiver.sv
// Receives rowSize, splitSize and pixel words, assembles a 28-pixel row.
// Optional trailing checksum word enabled by ROW_RECEIVER_CHECKSUM_EN.
module row_receiver
    import dcnn_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    row_receiver_if.slave bus
);

    rx_state_t        r_state;
    logic [IDX_W-1:0] r_pixel_cnt;
    logic [IDX_W-1:0] r_split_cnt;
    logic [IDX_W-1:0] r_split_size;
    logic [15:0]      r_row_len;
    logic             r_split_ack;
    logic             r_err;
`ifdef ROW_RECEIVER_CHECKSUM_EN
    logic [15:0]      r_sum;
`endif

    logic             w_xfer;
    logic             w_row_size_ok;
    logic             w_split_ok;
    logic [IDX_W-1:0] w_pixel_next;
    logic [IDX_W-1:0] w_split_next;
    logic             w_last_pixel;
    logic             w_split_done;
    logic             w_clr;
    logic             w_wr_en;
    logic             w_sum_bad;

    assign w_xfer        = bus.in_valid & bus.in_ready;
    assign w_row_size_ok = (bus.in_data != 16'd0) && (bus.in_data <= 16'(ROW_PIXELS));
    assign w_split_ok    = (bus.in_data != 16'd0) && (bus.in_data <= r_row_len);
    assign w_pixel_next  = r_pixel_cnt + 1'b1;
    assign w_split_next  = r_split_cnt + 1'b1;
    assign w_last_pixel  = ({11'd0, w_pixel_next} == r_row_len);
    assign w_split_done  = (w_split_next == r_split_size);

`ifdef ROW_RECEIVER_CHECKSUM_EN
    assign w_sum_bad = (r_state == ST_CHECK) && w_xfer && (bus.in_data != r_sum);
`else
    assign w_sum_bad = 1'b0;
`endif

    // A bad checksum wipes the partial row so nothing stale is left behind.
    assign w_clr   = ((r_state == ST_IDLE) && w_xfer && w_row_size_ok) || w_sum_bad;
    assign w_wr_en = (r_state == ST_GET_DATA) && w_xfer;

    rx_row_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_pixel_cnt),
        .i_wr_data (bus.in_data),
        .o_row     (bus.row_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pixel_cnt  <= '0;
            r_split_cnt  <= '0;
            r_split_size <= '0;
            r_row_len    <= '0;
            r_split_ack  <= 1'b0;
            r_err        <= 1'b0;
`ifdef ROW_RECEIVER_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_split_ack <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        if (w_row_size_ok) begin
                            r_row_len   <= bus.in_data;
                            r_pixel_cnt <= '0;
                            r_split_cnt <= '0;
                            r_state     <= ST_GET_SPLIT;
`ifdef ROW_RECEIVER_CHECKSUM_EN
                            r_sum       <= bus.in_data;
`endif
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_GET_SPLIT: begin
                    if (w_xfer) begin
                        if (w_split_ok) begin
                            r_split_size <= bus.in_data[IDX_W-1:0];
                            r_state      <= ST_GET_DATA;
`ifdef ROW_RECEIVER_CHECKSUM_EN
                            r_sum        <= r_sum + bus.in_data;
`endif
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (w_xfer) begin
                        r_pixel_cnt <= w_pixel_next;
`ifdef ROW_RECEIVER_CHECKSUM_EN
                        r_sum       <= r_sum + bus.in_data;
`endif
                        // The last pixel of the row also closes a short final split.
                        if (w_split_done || w_last_pixel) begin
                            r_split_ack <= 1'b1;
                            r_split_cnt <= '0;
                        end else begin
                            r_split_cnt <= w_split_next;
                        end
                        if (w_last_pixel) begin
`ifdef ROW_RECEIVER_CHECKSUM_EN
                            r_state <= ST_CHECK;
`else
                            r_state <= ST_HOLD;
`endif
                        end
                    end
                end
                ST_CHECK: begin
`ifdef ROW_RECEIVER_CHECKSUM_EN
                    if (w_xfer) begin
                        if (w_sum_bad) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                ST_HOLD: begin
                    if (bus.row_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state != ST_HOLD);
    assign bus.row_valid = (r_state == ST_HOLD);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.split_ack = r_split_ack;
    assign bus.err       = r_err;
    assign bus.row_len   = r_row_len;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_row_receiver.sv
// Directed bench for row_receiver: reset, split acks, long hold, errors, mid-row reset, stalls.
// Also covers the checksum word when ROW_RECEIVER_CHECKSUM_EN is defined.
module tb_row_receiver;
    import dcnn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    row_receiver_if bus();

    row_receiver u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_split = 0;
    int n_err   = 0;
    int n_rv    = 0;
    logic rv_d  = 1'b0;
    logic [15:0] tb_sum;
    logic [ROW_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    // Pulse and row counters sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.split_ack === 1'b1) n_split <= n_split + 1;
            if (bus.err === 1'b1) n_err <= n_err + 1;
            if (bus.row_valid === 1'b1 && rv_d !== 1'b1) n_rv <= n_rv + 1;
        end
        rv_d <= bus.row_valid;
    end

    task automatic send_word(input logic [15:0] d);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            done = (bus.in_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        tb_sum = tb_sum + d;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL send_word_timeout data=%h in_ready=%b expected 1", d, bus.in_ready);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic end_row();
`ifdef ROW_RECEIVER_CHECKSUM_EN
        send_word(tb_sum);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.row_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic collect_row(input logic [15:0] exp_len);
        logic [ROW_W-1:0] exp_row;
        exp_row = exp_q.pop_front();
        total++;
        if (bus.row_valid !== 1'b1) begin
            bad++;
            $display("FAIL row_valid got=%b exp=1", bus.row_valid);
        end
        total++;
        if (bus.row_out !== exp_row) begin
            bad++;
            $display("FAIL row_out got=%h exp=%h", bus.row_out[127:0], exp_row[127:0]);
        end
        total++;
        if (bus.row_len !== exp_len) begin
            bad++;
            $display("FAIL row_len got=%0d exp=%0d", bus.row_len, exp_len);
        end
        bus.row_ready = 1'b1;
        idle_cycle();
        bus.row_ready = 1'b0;
        total++;
        if (bus.dbg_state !== ST_IDLE || bus.row_valid !== 1'b0) begin
            bad++;
            $display("FAIL after_handshake state=%0d row_valid=%b exp state=0 row_valid=0",
                     bus.dbg_state, bus.row_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.row_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags in_ready=%b busy=%b row_valid=%b exp 1 0 0",
                     bus.in_ready, bus.busy, bus.row_valid);
        end
        total++;
        if (bus.row_out !== '0 || bus.row_len !== 16'd0) begin
            bad++;
            $display("FAIL reset_row row_len=%0d row_out_nonzero=%b exp 0 0",
                     bus.row_len, |bus.row_out);
        end
        total++;
        if (bus.split_ack !== 1'b0 || bus.err !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_pulses split_ack=%b err=%b state=%0d exp 0 0 0",
                     bus.split_ack, bus.err, bus.dbg_state);
        end
    endtask

    task automatic test_basic();
        logic [ROW_W-1:0] e;
        e = 448'h0004_0003_0002_0001;
        exp_q.push_back(e);
        tb_sum = '0;
        send_word(16'd4);
        send_word(16'd2);
        for (int i = 1; i <= 4; i++) begin
            send_word(16'(i));
            total++;
            if (bus.split_ack !== ((i % 2) == 0)) begin
                bad++;
                $display("FAIL basic_split_ack pixel=%0d got=%b exp=%b", i, bus.split_ack, (i % 2) == 0);
            end
        end
        end_row();
        collect_row(16'd4);
    endtask

    task automatic test_full_row();
        logic [ROW_W-1:0] e;
        int s0;
        e = '0;
        for (int j = 0; j < ROW_PIXELS; j++) e[16*j +: 16] = 16'(j);
        exp_q.push_back(e);
        s0 = n_split;
        tb_sum = '0;
        send_word(16'd28);
        send_word(16'd5);
        for (int j = 0; j < ROW_PIXELS; j++) send_word(16'(j));
        end_row();
        for (int c = 0; c < 10; c++) begin
            total++;
            if (bus.row_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL hold_cycle c=%0d row_valid=%b in_ready=%b busy=%b exp 1 0 1",
                         c, bus.row_valid, bus.in_ready, bus.busy);
            end
            idle_cycle();
        end
        total++;
        if (n_split - s0 !== 6) begin
            bad++;
            $display("FAIL full_split_count got=%0d exp=6", n_split - s0);
        end
        collect_row(16'd28);
    endtask

    task automatic test_errors();
        int e0, r0;
        e0 = n_err;
        r0 = n_rv;
        send_word(16'd0);
        total++;
        if (bus.err !== 1'b1 || bus.dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL err_size0 err=%b state=%0d exp 1 0", bus.err, bus.dbg_state);
        end
        send_word(16'd29);
        total++;
        if (bus.err !== 1'b1 || bus.dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL err_size29 err=%b state=%0d exp 1 0", bus.err, bus.dbg_state);
        end
        send_word(16'd3);
        total++;
        if (bus.err !== 1'b0 || bus.dbg_state !== ST_GET_SPLIT) begin
            bad++;
            $display("FAIL size3_ok err=%b state=%0d exp 0 1", bus.err, bus.dbg_state);
        end
        send_word(16'd4);
        total++;
        if (bus.err !== 1'b1 || bus.dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL err_split4 err=%b state=%0d exp 1 0", bus.err, bus.dbg_state);
        end
        settle();
        total++;
        if (n_err - e0 !== 3 || n_rv - r0 !== 0) begin
            bad++;
            $display("FAIL err_counts errs=%0d rows=%0d exp 3 0", n_err - e0, n_rv - r0);
        end
    endtask

    task automatic test_reset_mid();
        logic [ROW_W-1:0] e;
        int e0, r0;
        e0 = n_err;
        r0 = n_rv;
        tb_sum = '0;
        send_word(16'd6);
        send_word(16'd3);
        send_word(16'h1111);
        send_word(16'h2222);
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.row_valid !== 1'b0 || bus.row_out !== '0 || bus.row_len !== 16'd0) begin
            bad++;
            $display("FAIL midreset busy=%b row_valid=%b row_len=%0d out_nonzero=%b exp 0 0 0 0",
                     bus.busy, bus.row_valid, bus.row_len, |bus.row_out);
        end
        e = '0;
        e[31:0] = 32'h5555_AAAA;
        exp_q.push_back(e);
        tb_sum = '0;
        send_word(16'd2);
        send_word(16'd1);
        send_word(16'hAAAA);
        total++;
        if (bus.split_ack !== 1'b1) begin
            bad++;
            $display("FAIL midreset_split1 got=%b exp=1", bus.split_ack);
        end
        send_word(16'h5555);
        end_row();
        collect_row(16'd2);
        settle();
        total++;
        if (n_err - e0 !== 0 || n_rv - r0 !== 1) begin
            bad++;
            $display("FAIL midreset_counts errs=%0d rows=%0d exp 0 1", n_err - e0, n_rv - r0);
        end
    endtask

    task automatic test_stall();
        logic [ROW_W-1:0] e;
        int s0;
        e = '0;
        e[47:0] = 48'h0009_0008_0007;
        for (int mode = 0; mode < 2; mode++) begin
            exp_q.push_back(e);
            s0 = n_split;
            tb_sum = '0;
            send_word(16'd3);
            if (mode == 1) idle_cycle();
            send_word(16'd3);
            for (int j = 7; j <= 9; j++) begin
                if (mode == 1) begin
                    idle_cycle();
                    total++;
                    if (bus.dbg_state !== ST_GET_DATA) begin
                        bad++;
                        $display("FAIL stall_state got=%0d exp=2", bus.dbg_state);
                    end
                end
                send_word(16'(j));
            end
            end_row();
            collect_row(16'd3);
            settle();
            total++;
            if (n_split - s0 !== 1) begin
                bad++;
                $display("FAIL stall_split_count mode=%0d got=%0d exp=1", mode, n_split - s0);
            end
        end
    endtask

`ifdef ROW_RECEIVER_CHECKSUM_EN
    task automatic test_checksum();
        logic [ROW_W-1:0] e;
        int r0;
        e = '0;
        e[31:0] = 32'h0020_0010;
        exp_q.push_back(e);
        send_word(16'd2);
        send_word(16'd2);
        send_word(16'h0010);
        send_word(16'h0020);
        send_word(16'h0034);
        collect_row(16'd2);
        settle();
        r0 = n_rv;
        send_word(16'd2);
        send_word(16'd2);
        send_word(16'h0010);
        send_word(16'h0020);
        send_word(16'h0035);
        total++;
        if (bus.err !== 1'b1 || bus.row_valid !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL csum_bad err=%b row_valid=%b state=%0d exp 1 0 0",
                     bus.err, bus.row_valid, bus.dbg_state);
        end
        settle();
        total++;
        if (n_rv - r0 !== 0) begin
            bad++;
            $display("FAIL csum_bad_rows got=%0d exp=0", n_rv - r0);
        end
    endtask
`endif

    initial begin
        tb_sum = '0;
        test_reset();
        test_basic();
        test_full_row();
        test_errors();
        test_reset_mid();
        test_stall();
`ifdef ROW_RECEIVER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
